// File: rtl/game_timer_if.sv
// Game-state inputs and timer outputs exchanged between the game controller and game_timer.
interface game_timer_if;
  logic [4:0] state;
  logic       time_up;
  logic       time_down;
  logic       delayover;
  logic       timeover;
  logic [6:0] time_left;
  logic       sec_tick;

  modport master (
    output state, time_up, time_down,
    input  delayover, timeover, time_left, sec_tick
  );

  modport slave (
    input  state, time_up, time_down,
    output delayover, timeover, time_left, sec_tick
  );
endinterface

// File: rtl/game_timer.sv
// Second prescaler, pre-game delay counter, adjustable duration setting and countdown of
// the seconds remaining, all driven by the externally supplied game state code.
module game_timer #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned DELAY_SEC   = 3,
  parameter int unsigned DEFAULT_SEC = 30,
  parameter int unsigned MAX_SEC     = 99
) (
  input  logic            clk,
  input  logic            rst_n,
  game_timer_if.slave     bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DELAY_SEC > 0) ? $clog2(DELAY_SEC + 1) : 1;
  localparam int unsigned TW = 7;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DELAY_MAX  = DW'(DELAY_SEC);
  localparam logic [TW-1:0] SET_MAX    = TW'(MAX_SEC);
  localparam logic [TW-1:0] SET_DEF    = TW'(DEFAULT_SEC);

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_WAIT_SET = 3'd1,
    ST_DELAY    = 3'd2,
    ST_RUN      = 3'd3,
    ST_HALT     = 3'd4
  } game_st_e;

  game_st_e        st_c;
  logic            running_c;
  logic            sec_tick_c;
  logic            delayover_c;
  logic            timeover_c;

  logic [PW-1:0]   presc_q,     presc_d;
  logic [DW-1:0]   dcnt_q,      dcnt_d;
  logic [TW-1:0]   setting_q,   setting_d;
  logic [TW-1:0]   time_left_q, time_left_d;

  // Unused state codes 5..31 decode as the start state.
  always_comb begin
    st_c = ST_START;
    if (bus.state <= 5'd4) st_c = game_st_e'(bus.state[2:0]);
  end

  always_comb begin
    running_c   = (st_c == ST_DELAY) || (st_c == ST_RUN);
    sec_tick_c  = running_c && (presc_q == PRESC_LAST);
    delayover_c = (st_c == ST_DELAY) && (dcnt_q == DELAY_MAX);
    timeover_c  = ((st_c == ST_RUN) || (st_c == ST_HALT)) && (time_left_q == '0);
  end

  // Next-state logic for prescaler, delay counter, setting and countdown.
  always_comb begin
    presc_d     = '0;
    dcnt_d      = '0;
    setting_d   = setting_q;
    time_left_d = time_left_q;

    // Clearing once the delay is over lets the running state begin on a full second.
    if (running_c && !delayover_c && (presc_q != PRESC_LAST))
      presc_d = presc_q + PW'(1);

    if (st_c == ST_DELAY) begin
      dcnt_d = dcnt_q;
      if (sec_tick_c && (dcnt_q != DELAY_MAX)) dcnt_d = dcnt_q + DW'(1);
    end

    if (st_c == ST_WAIT_SET) begin
      if (bus.time_up && !bus.time_down && (setting_q < SET_MAX))
        setting_d = setting_q + TW'(1);
      else if (bus.time_down && !bus.time_up && (setting_q > TW'(1)))
        setting_d = setting_q - TW'(1);
    end

    case (st_c)
      ST_START, ST_WAIT_SET, ST_DELAY: time_left_d = setting_q;
      ST_RUN: if (sec_tick_c && (time_left_q != '0)) time_left_d = time_left_q - TW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      presc_q     <= '0;
      dcnt_q      <= '0;
      setting_q   <= SET_DEF;
      time_left_q <= SET_DEF;
    end else begin
      presc_q     <= presc_d;
      dcnt_q      <= dcnt_d;
      setting_q   <= setting_d;
      time_left_q <= time_left_d;
    end
  end

  assign bus.sec_tick  = sec_tick_c;
  assign bus.delayover = delayover_c;
  assign bus.timeover  = timeover_c;
  assign bus.time_left = time_left_q;

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50000000: clk cycles per game second.
REQ-002 SHALL provide parameter DELAY_SEC, default 3: pre-game delay in seconds.
REQ-003 SHALL provide parameter DEFAULT_SEC, default 30: game duration after reset.
REQ-004 SHALL provide parameter MAX_SEC, default 99: upper bound on game duration (must be <=127).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port state, input, 5 bits: game state code (0 start, 1 wait for time set, 2 delay, 3 game running, 4 game halt).
REQ-009 SHALL have port time_up, input, 1 bit: one-cycle pulse that raises the duration setting.
REQ-010 SHALL have port time_down, input, 1 bit: one-cycle pulse that lowers the duration setting.
REQ-011 SHALL have port delayover, output, 1 bit: pre-game delay complete.
REQ-012 SHALL have port timeover, output, 1 bit: game time exhausted.
REQ-013 SHALL have port time_left, output, 7 bits: seconds remaining, unsigned.
REQ-014 SHALL have port sec_tick, output, 1 bit: one-cycle pulse at each game-second boundary.

Function
REQ-015 SHALL treat a state code of 5..31 exactly as code 0.
REQ-016 SHALL run the prescaler (0..TICK_DIV-1, wrapping to 0) only while state is 2 or 3, and hold it at 0 otherwise.
REQ-017 SHALL drive sec_tick combinationally high when the prescaler is running and equals TICK_DIV-1.
REQ-018 SHALL clear the prescaler at the next edge when state==2 and delayover==1, so state 3 starts with a full second.
REQ-019 SHALL, in state 1: on time_up alone, increment the setting, saturating at MAX_SEC.
REQ-020 SHALL, in state 1: on time_down alone, decrement the setting, saturating at 1.
REQ-021 SHALL, in state 1: leave the setting unchanged when time_up and time_down are both high; ignore both inputs in every other state.
REQ-022 SHALL load time_left from the setting at every edge while state is 0, 1 or 2, so time_left lags a setting change by one cycle.
REQ-023 SHALL, in state 2, increment the delay counter on each sec_tick, saturating at DELAY_SEC; the counter is held at 0 in all other states.
REQ-024 SHALL drive delayover combinationally as (state==2 && delay counter==DELAY_SEC), which is high from the cycle after the DELAY_SEC-th sec_tick.
REQ-025 SHALL, in state 3, decrement time_left on each sec_tick, saturating at 0.
REQ-026 SHALL drive timeover combinationally as ((state==3 || state==4) && time_left==0).
REQ-027 SHALL freeze time_left and the setting in state 4; timeover stays 0 when the game ended by the score path with time_left>0.
REQ-028 SHALL retain the setting across games (a transition 4->0 by reset is the only way it returns to DEFAULT_SEC).

Reset
REQ-029 SHALL, while rst_n==1 at an edge, set prescaler=0, delay counter=0, setting=DEFAULT_SEC, time_left=DEFAULT_SEC.
REQ-030 SHALL, with state forced to 0 by the same reset, produce delayover=0, timeover=0 and sec_tick=0.
REQ-031 SHALL let reset asserted mid-countdown take effect at the next edge with no residual tick.

Verification (TICK_DIV=4, DELAY_SEC=2, DEFAULT_SEC=3, MAX_SEC=5; cycle 0 = first cycle in the state)
REQ-032 SHALL verify reset, then state=1 with three time_up pulses: setting and time_left saturate at 5; both inputs pulsed together -> 5 unchanged.
REQ-033 SHALL verify state=1 with five time_down pulses from 3: time_left saturates at 1.
REQ-034 SHALL verify state=2 from reset: sec_tick at cycles 3 and 7; delayover=1 from cycle 8; prescaler=0 on the next edge.
REQ-035 SHALL verify state=3 with setting 3: time_left becomes 2, 1, 0 at cycles 4, 8, 12; timeover=1 from cycle 12; state=4 -> time_left holds 0 and timeover stays 1.
REQ-036 SHALL verify state 3->4 at cycle 6 (score path): time_left frozen at 2, timeover=0, sec_tick=0.
REQ-037 SHALL verify rst_n pulsed at cycle 9 of state 3: time_left=3 and delayover=timeover=0 on the next cycle; state=7 behaves as state 0.
